reg_wb_ctrl: RTL and testbench
==============================

Name: reg_wb_ctrl

Overview:
- Write-side controller for the 32x32 integer register file.
- Merges results from the single-cycle ALU path and from long-latency units (load/store unit, divider) into the single register-file write port (write / wrAddr / wrData). At most one write per cycle.
- Long-latency results are buffered in a small FIFO.
- A pending-destination scoreboard and a same-cycle forwarding path let the decode stage detect and resolve RAW hazards.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 4, long-latency result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result will be accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  long-latency result present.
- mem_ready  out  1  FIFO can accept a result.
- mem_rd  in  5  long-latency destination register.
- mem_data  in  XLEN  long-latency result.
- issue_valid  in  1  long-latency instruction issued this cycle.
- issue_rd  in  5  destination register of the issued instruction.
- issue_busy  out  1  issue_rd is already pending.
- rs1  in  5  decode source address A.
- rs2  in  5  decode source address B.
- rs1_busy  out  1  stall required for rs1.
- rs2_busy  out  1  stall required for rs2.
- rs1_fwd  out  1  forward fwd_data for rs1.
- rs2_fwd  out  1  forward fwd_data for rs2.
- fwd_data  out  XLEN  forwarded value; equals wrData.
- write  out  1  register-file write enable.
- wrAddr  out  5  register-file write address.
- wrData  out  XLEN  register-file write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - write=0, wrAddr=0, wrData=0.
  - FIFO empty; pending bits all 0.
  - mem_ready=0 and alu_ready=0 while reset is low.
- mem_ready = !fifo_full. Push when mem_valid && mem_ready. mem_ready does not depend on a same-cycle pop.
- alu_ready = !fifo_full. When the FIFO is full, the FIFO head has priority and the ALU holds its result.
- Arbitration, evaluated each cycle:
  1. If alu_valid && alu_ready, the ALU result wins.
  2. Otherwise, if the FIFO is non-empty, pop the head.
  3. Otherwise, no write.
- Output timing: the winner is registered into write/wrAddr/wrData, so the register file captures it on the following edge. Latency is 1 cycle from acceptance to write=1, and 2 edges to register-file update.
- Register x0:
  - An accepted ALU result with alu_rd=0 is consumed with no write.
  - A mem result with mem_rd=0 is accepted but not stored.
  - write is never 1 with wrAddr=0.
- FIFO behaviour:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
  - A push to an empty FIFO is not visible to the arbiter until the next cycle (no bypass).
- Scoreboard (pending[31:1]):
  - issue_valid with issue_rd!=0 sets pending[issue_rd].
  - A FIFO pop for rd clears pending[rd] in the same edge that loads the output register.
  - Set and clear of the same rd in the same cycle: set wins.
  - issue_busy = pending[issue_rd]. The issuer must not issue while issue_busy=1; if it does, the bit stays set.
- Hazard outputs:
  - rsN_busy = pending[rsN] (rsN!=0).
  - rsN_fwd = write && wrAddr==rsN && rsN!=0.
  - Busy and fwd are both combinational.

Optional Feature:
- Macro: REG_WB_FWD_EN.
- Defined: forwarding active as described above.
- Undefined:
  - rs1_fwd, rs2_fwd and fwd_data are tied to 0.
  - rsN_busy additionally asserts when write && wrAddr==rsN && rsN!=0, giving a one-cycle stall instead of a bypass.

Test Plan:
- Reset low mid-stream with 3 FIFO entries -> immediately write=0, FIFO empty, pending=0; after release mem_ready=1.
- alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> next cycle write=1, wrAddr=5, wrData=0xDEADBEEF; rs1=5 gives rs1_fwd=1, fwd_data=0xDEADBEEF (with REG_WB_FWD_EN), otherwise rs1_busy=1.
- issue rd=7, then mem result rd=7 data=0x12 while ALU idle -> rs2=7 busy until the pop; then write=1, wrAddr=7, wrData=0x12, and pending[7] clears on the same edge.
- Hold alu_valid every cycle while pushing 4 mem results (FIFO_DEPTH=4):
  - While the FIFO is not full, the ALU wins and mem results accumulate.
  - On full: mem_ready=0, alu_ready=0, and the head drains.
  - Order of mem writes matches push order across pointer wrap.
- alu_rd=0 and mem_rd=0 results -> no write pulse, no FIFO occupancy change.
- issue_valid rd=9 in the same cycle that the FIFO head with rd=9 pops -> pending[9] remains 1 and issue_busy=1 next cycle.

Source files
------------

// File: rtl/reg_wb_ctrl_if.sv
// rtl/reg_wb_ctrl_if.sv - pipeline-to-writeback bus for reg_wb_ctrl
//
// Purpose: groups the ALU result, long-latency result, issue/scoreboard,
// decode hazard and register-file write signals of reg_wb_ctrl.
// Modports:
//   master - pipeline side: drives results, issue and decode sources;
//            observes ready, busy/fwd and the register-file write port.
//   slave  - reg_wb_ctrl side (the mirror image of master).
// Signals:
//   alu_valid/alu_ready/alu_rd/alu_data   single-cycle ALU result
//   mem_valid/mem_ready/mem_rd/mem_data   long-latency result
//   issue_valid/issue_rd/issue_busy       long-latency issue check
//   rs1/rs2, rs1_busy/rs2_busy            decode hazard query
//   rs1_fwd/rs2_fwd/fwd_data              decode forwarding
//   write/wrAddr/wrData                   register-file write port

interface reg_wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;

  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_busy;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rs1_fwd;
  logic            rs2_fwd;
  logic [XLEN-1:0] fwd_data;

  logic            write;
  logic [4:0]      wrAddr;
  logic [XLEN-1:0] wrData;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    output rs1, rs2,
    input  alu_ready, mem_ready, issue_busy,
    input  rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, fwd_data,
    input  write, wrAddr, wrData
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    input  rs1, rs2,
    output alu_ready, mem_ready, issue_busy,
    output rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, fwd_data,
    output write, wrAddr, wrData
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register-file write-side controller with result FIFO and scoreboard
//
// Purpose: merges single-cycle ALU results and buffered long-latency results
// into the one register-file write port, tracks pending long-latency
// destinations and reports decode-stage RAW hazards.
// Parameters: XLEN data width; FIFO_DEPTH long-latency buffer entries
// (power of two, >= 2).
// Configuration macro: REG_WB_FWD_EN - when defined, a value on the write
// port is forwarded to decode (rsN_fwd/fwd_data); when undefined, forwarding
// outputs are 0 and a matching write port stalls decode for one cycle instead.
// Ports:
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-low reset
//   bus    reg_wb_ctrl_if.slave (results, issue, hazard, write port)

module reg_wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  reg_wb_ctrl_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = FIFO_DEPTH;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Long-latency result buffer (storage needs no reset: count gates reads)
  wb_entry_t        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  // Registered write port
  logic             write_q,   write_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;

  // Pending-destination scoreboard; bit 0 is never set
  logic [31:0]      pending_q, pending_d;

  logic      fifo_full;
  logic      fifo_empty;
  logic      accept_ok;
  logic      alu_accept;
  logic      mem_accept;
  logic      push;
  logic      pop;
  wb_entry_t head;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Both sources are refused while in reset. Readiness depends only on the
  // current occupancy so no combinational path runs from a pop to a push.
  assign accept_ok  = reset && !fifo_full;

  assign alu_accept = bus.alu_valid && accept_ok;
  assign mem_accept = bus.mem_valid && accept_ok;

  // x0 results are acknowledged but never occupy a slot
  assign push = mem_accept && (bus.mem_rd != 5'd0);

  // ALU has priority unless the FIFO is full (then alu_ready is low)
  assign pop  = !alu_accept && !fifo_empty;

  assign bus.alu_ready = accept_ok;
  assign bus.mem_ready = accept_ok;

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{rd: bus.mem_rd, data: bus.mem_data};
    end
  end

  // ---------------------------------------------------------------------
  // Write-port arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    write_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_accept) begin
      // ALU result for x0 is consumed with no write
      if (bus.alu_rd != 5'd0) begin
        write_d   = 1'b1;
        wr_addr_d = bus.alu_rd;
        wr_data_d = bus.alu_data;
      end
    end else if (pop) begin
      if (head.rd != 5'd0) begin
        write_d   = 1'b1;
        wr_addr_d = head.rd;
        wr_data_d = head.data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard: a new issue overrides a same-cycle retirement
  // ---------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head.rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign bus.write  = write_q;
  assign bus.wrAddr = wr_addr_q;
  assign bus.wrData = wr_data_q;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic rs1_pend, rs2_pend;
  logic rs1_hit,  rs2_hit;

  assign rs1_pend = pending_q[bus.rs1];
  assign rs2_pend = pending_q[bus.rs2];

  // Source matches the value being written this cycle
  assign rs1_hit  = write_q && (wr_addr_q == bus.rs1) && (bus.rs1 != 5'd0);
  assign rs2_hit  = write_q && (wr_addr_q == bus.rs2) && (bus.rs2 != 5'd0);

  assign bus.issue_busy = pending_q[bus.issue_rd];

`ifdef REG_WB_FWD_EN
  assign bus.rs1_busy = rs1_pend;
  assign bus.rs2_busy = rs2_pend;
  assign bus.rs1_fwd  = rs1_hit;
  assign bus.rs2_fwd  = rs2_hit;
  assign bus.fwd_data = wr_data_q;
`else
  // Without the bypass, a matching write stalls decode until the
  // register file holds the value
  assign bus.rs1_busy = rs1_pend || rs1_hit;
  assign bus.rs2_busy = rs2_pend || rs2_hit;
  assign bus.rs1_fwd  = 1'b0;
  assign bus.rs2_fwd  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb/tb_reg_wb_ctrl.sv - directed self-checking bench for reg_wb_ctrl

module tb_reg_wb_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  reg_wb_ctrl_if #(.XLEN(32)) bus ();

  reg_wb_ctrl #(
    .XLEN       (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to one time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    bus.issue_valid = v;
    bus.issue_rd    = rd;
  endtask

  task automatic expect_wb(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_write"}, bus.write, w);
    if (w) begin
      check({tag, "_addr"}, bus.wrAddr, a);
      check({tag, "_data"}, bus.wrData, d);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    issue(0, 0);
    bus.rs1 = 0;
    bus.rs2 = 0;

    // ---------------- reset state ----------------
    #1 reset = 1'b0;
    #1;
    check("rst_write", bus.write, 0);
    check("rst_wraddr", bus.wrAddr, 0);
    check("rst_wrdata", bus.wrData, 0);
    check("rst_mem_ready", bus.mem_ready, 0);
    check("rst_alu_ready", bus.alu_ready, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rel_mem_ready", bus.mem_ready, 1);
    check("rel_alu_ready", bus.alu_ready, 1);

    // ---------------- ALU write + forwarding ----------------
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    #1 check("b_alu_ready", bus.alu_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_wb("b_wb", 1, 5, 32'hDEADBEEF);
    bus.rs1 = 5;
    #1;
`ifdef REG_WB_FWD_EN
    check("b_rs1_fwd", bus.rs1_fwd, 1);
    check("b_fwd_data", bus.fwd_data, 32'hDEADBEEF);
    check("b_rs1_busy", bus.rs1_busy, 0);
`else
    check("b_rs1_busy", bus.rs1_busy, 1);
    check("b_rs1_fwd", bus.rs1_fwd, 0);
    check("b_fwd_data", bus.fwd_data, 0);
`endif
    tick();
    expect_wb("b_idle", 0, 0, 0);
    check("b_rs1_busy_after", bus.rs1_busy, 0);
    check("b_rs1_fwd_after", bus.rs1_fwd, 0);
    bus.rs1 = 0;

    // ---------------- scoreboard through the FIFO ----------------
    issue(1, 7);
    #1 check("c_issue_busy_pre", bus.issue_busy, 0);
    tick();
    issue(0, 7);
    bus.rs2 = 7;
    #1;
    check("c_rs2_busy", bus.rs2_busy, 1);
    check("c_issue_busy", bus.issue_busy, 1);
    drive(0, 0, 0, 1, 7, 32'h12);
    #1 check("c_mem_ready", bus.mem_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    expect_wb("c_no_bypass", 0, 0, 0);
    check("c_rs2_busy_inpop", bus.rs2_busy, 1);
    tick();
    expect_wb("c_pop", 1, 7, 32'h12);
    check("c_issue_busy_clr", bus.issue_busy, 0);
`ifdef REG_WB_FWD_EN
    check("c_rs2_busy_clr", bus.rs2_busy, 0);
    check("c_rs2_fwd", bus.rs2_fwd, 1);
    check("c_fwd_data", bus.fwd_data, 32'h12);
`else
    check("c_rs2_busy_stall", bus.rs2_busy, 1);
    check("c_rs2_fwd", bus.rs2_fwd, 0);
`endif
    tick();
    expect_wb("c_idle", 0, 0, 0);
    check("c_rs2_busy_end", bus.rs2_busy, 0);
    bus.rs2 = 0;

    // ---------------- ALU priority, FIFO fill, drain and wrap ----------------
    drive(1, 10, 32'hA0, 1, 11, 32'hB0);
    #1;
    check("d0_alu_ready", bus.alu_ready, 1);
    check("d0_mem_ready", bus.mem_ready, 1);
    tick();
    expect_wb("d_e1", 1, 10, 32'hA0);
    drive(1, 10, 32'hA1, 1, 12, 32'hB1);
    tick();
    expect_wb("d_e2", 1, 10, 32'hA1);
    drive(1, 10, 32'hA2, 1, 13, 32'hB2);
    tick();
    expect_wb("d_e3", 1, 10, 32'hA2);
    drive(1, 10, 32'hA3, 1, 14, 32'hB3);
    #1 check("d3_mem_ready", bus.mem_ready, 1);
    tick();
    expect_wb("d_e4", 1, 10, 32'hA3);
    drive(1, 10, 32'hA4, 1, 15, 32'hB4);
    #1;
    check("d4_full_mem_ready", bus.mem_ready, 0);
    check("d4_full_alu_ready", bus.alu_ready, 0);
    tick();
    expect_wb("d_e5", 1, 11, 32'hB0);
    #1;
    check("d5_alu_ready", bus.alu_ready, 1);
    check("d5_mem_ready", bus.mem_ready, 1);
    tick();
    expect_wb("d_e6", 1, 10, 32'hA4);
    drive(1, 10, 32'hA5, 0, 0, 0);
    #1 check("d6_full_alu_ready", bus.alu_ready, 0);
    tick();
    expect_wb("d_e7", 1, 12, 32'hB1);
    tick();
    expect_wb("d_e8", 1, 10, 32'hA5);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    expect_wb("d_e9", 1, 13, 32'hB2);
    tick();
    expect_wb("d_e10", 1, 14, 32'hB3);
    tick();
    expect_wb("d_e11", 1, 15, 32'hB4);
    tick();
    expect_wb("d_e12", 0, 0, 0);

    // ---------------- x0 results ----------------
    drive(1, 0, 32'h55, 1, 0, 32'h66);
    #1;
    check("e_alu_ready", bus.alu_ready, 1);
    check("e_mem_ready", bus.mem_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_wb("e_x0_a", 0, 0, 0);
    tick();
    expect_wb("e_x0_b", 0, 0, 0);

    // ---------------- issue and retire of same rd in one cycle ----------------
    issue(1, 9);
    tick();
    issue(0, 9);
    drive(0, 0, 0, 1, 9, 32'h99);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    issue(1, 9);
    bus.rs1 = 9;
    #1;
    check("f_issue_busy_pre", bus.issue_busy, 1);
    check("f_rs1_busy_pre", bus.rs1_busy, 1);
    tick();
    issue(0, 9);
    #1;
    expect_wb("f_pop", 1, 9, 32'h99);
    check("f_issue_busy", bus.issue_busy, 1);
    check("f_rs1_busy", bus.rs1_busy, 1);
    tick();
    expect_wb("f_idle", 0, 0, 0);
    check("f_issue_busy_held", bus.issue_busy, 1);
    bus.rs1 = 0;

    // ---------------- asynchronous reset mid-stream ----------------
    drive(1, 20, 32'hC0, 1, 21, 32'hD1);
    issue(1, 21);
    tick();
    issue(0, 0);
    drive(1, 20, 32'hC1, 1, 22, 32'hD2);
    tick();
    drive(1, 20, 32'hC2, 1, 23, 32'hD3);
    tick();
    expect_wb("g_pre", 1, 20, 32'hC2);
    reset = 1'b0;
    bus.rs1 = 21;
    bus.rs2 = 9;
    #1;
    check("g_rst_write", bus.write, 0);
    check("g_rst_wraddr", bus.wrAddr, 0);
    check("g_rst_wrdata", bus.wrData, 0);
    check("g_rst_mem_ready", bus.mem_ready, 0);
    check("g_rst_alu_ready", bus.alu_ready, 0);
    check("g_rst_rs1_busy", bus.rs1_busy, 0);
    check("g_rst_rs2_busy", bus.rs2_busy, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1 check("g_rel_mem_ready", bus.mem_ready, 1);
    tick();
    expect_wb("g_empty_a", 0, 0, 0);
    tick();
    expect_wb("g_empty_b", 0, 0, 0);
    check("g_rs1_busy_end", bus.rs1_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
